// File: rtl/jb_nco_ctrl_if.sv
// Coefficient update channel: register/control logic (master) offers a new
// NCO coefficient; the sequencer (slave) accepts it with cfg_ready.
interface jb_nco_ctrl_if #(
  parameter int NCO_COEF_WIDTH = 40
);
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [NCO_COEF_WIDTH-1:0] cfg_coef;
  logic                      cfg_sync;

  modport master (
    output cfg_valid,
    output cfg_coef,
    output cfg_sync,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_coef,
    input  cfg_sync,
    output cfg_ready
  );
endinterface

// File: rtl/jb_nco_ctrl.sv
// NCO sequencer: drives the sample phase counter and the active frequency
// coefficient of the shared NCO datapath, applies coefficient updates either
// immediately or at the next counter wrap, and produces nco_vld aligned with
// nco_sincos while masking samples computed across a coefficient change.
module jb_nco_ctrl #(
  parameter int NCO_COEF_WIDTH  = 40,
  parameter int NCO_COUNT_WIDTH = 39,
  parameter int NCO_LATENCY     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       sample_en,
  input  logic [NCO_COUNT_WIDTH-1:0] cnt_max,
  jb_nco_ctrl_if.slave               cfg,
  output logic [NCO_COUNT_WIDTH-1:0] nco_cntr,
  output logic [NCO_COEF_WIDTH-1:0]  nco_coef,
  output logic                       nco_vld,
  output logic                       upd_done,
  output logic [1:0]                 state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PEND  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // FLUSH length counter must hold NCO_LATENCY-1.
  localparam int FLUSH_W = (NCO_LATENCY > 1) ? $clog2(NCO_LATENCY) : 1;
  localparam logic [FLUSH_W-1:0]         FLUSH_LOAD = FLUSH_W'(NCO_LATENCY - 1);
  localparam logic [FLUSH_W-1:0]         FLUSH_ZERO = FLUSH_W'(0);
  localparam logic [FLUSH_W-1:0]         FLUSH_ONE  = FLUSH_W'(1);
  localparam logic [NCO_COUNT_WIDTH-1:0] CNT_ZERO   = NCO_COUNT_WIDTH'(0);
  localparam logic [NCO_COUNT_WIDTH-1:0] CNT_ONE    = NCO_COUNT_WIDTH'(1);
  localparam logic [NCO_COEF_WIDTH-1:0]  COEF_ZERO  = NCO_COEF_WIDTH'(0);

  state_t                       state_r;
  state_t                       state_nxt_s;
  logic [NCO_COUNT_WIDTH-1:0]   cntr_r;
  logic [NCO_COEF_WIDTH-1:0]    coef_r;
  logic [NCO_COEF_WIDTH-1:0]    pend_r;
  logic [NCO_LATENCY:0]         vld_pipe_r;
  logic [FLUSH_W-1:0]           flush_cnt_r;
  logic                         upd_done_r;

  logic                         wrap_s;
  logic                         cfg_ready_s;
  logic                         abort_s;       // enable dropped while active
  logic                         load_cfg_s;    // nco_coef <= cfg_coef
  logic                         load_pend_s;   // nco_coef <= pending value
  logic                         store_pend_s;  // capture a sync request
  logic                         restart_s;     // phase restart: counter 0, pipe flushed
  logic                         vld_in_s;

  assign wrap_s = sample_en & (cntr_r == cnt_max);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; a dropped enable overrides any same-cycle wrap or update.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) state_nxt_s = ST_RUN;
        else        state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!enable)                                state_nxt_s = ST_IDLE;
        else if (cfg.cfg_valid && !cfg.cfg_sync)    state_nxt_s = ST_FLUSH;
        else if (cfg.cfg_valid)                     state_nxt_s = ST_PEND;
        else                                        state_nxt_s = ST_RUN;
      end
      ST_PEND: begin
        if (!enable)     state_nxt_s = ST_IDLE;
        else if (wrap_s) state_nxt_s = ST_FLUSH;
        else             state_nxt_s = ST_PEND;
      end
      ST_FLUSH: begin
        if (!enable)                       state_nxt_s = ST_IDLE;
        else if (flush_cnt_r == FLUSH_ZERO) state_nxt_s = ST_RUN;
        else                               state_nxt_s = ST_FLUSH;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-state control strobes for the datapath and the handshake.
  always_comb begin
    cfg_ready_s  = 1'b0;
    abort_s      = 1'b0;
    load_cfg_s   = 1'b0;
    load_pend_s  = 1'b0;
    store_pend_s = 1'b0;
    restart_s    = 1'b0;
    vld_in_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // IDLE always applies a request at once, whatever cfg_sync says.
        cfg_ready_s = 1'b1;
        load_cfg_s  = cfg.cfg_valid;
      end
      ST_RUN: begin
        cfg_ready_s = enable;
        abort_s     = ~enable;
        vld_in_s    = sample_en & enable;
        if (enable && cfg.cfg_valid) begin
          if (cfg.cfg_sync) begin
            store_pend_s = 1'b1;
          end else begin
            load_cfg_s = 1'b1;
            restart_s  = 1'b1;
          end
        end else begin
          store_pend_s = 1'b0;
        end
      end
      ST_PEND: begin
        abort_s  = ~enable;
        vld_in_s = sample_en & enable;
        if (enable && wrap_s) begin
          load_pend_s = 1'b1;
          restart_s   = 1'b1;
        end else begin
          load_pend_s = 1'b0;
        end
      end
      ST_FLUSH: begin
        abort_s  = ~enable;
        vld_in_s = sample_en & enable;
      end
      default: begin
        cfg_ready_s = 1'b0;
      end
    endcase
  end

  assign cfg.cfg_ready = cfg_ready_s;

  // Phase counter: held at 0 in IDLE, restarted on updates, wraps at cnt_max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cntr_r <= CNT_ZERO;
    end else if ((state_r == ST_IDLE) || abort_s || restart_s) begin
      cntr_r <= CNT_ZERO;
    end else if (sample_en) begin
      cntr_r <= wrap_s ? CNT_ZERO : (cntr_r + CNT_ONE);
    end else begin
      cntr_r <= cntr_r;
    end
  end

  // Active coefficient and pending (wrap-aligned) coefficient.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_r <= COEF_ZERO;
      pend_r <= COEF_ZERO;
    end else begin
      if (load_cfg_s) begin
        coef_r <= cfg.cfg_coef;
      end else if (load_pend_s) begin
        coef_r <= pend_r;
      end else begin
        coef_r <= coef_r;
      end
      if (abort_s || load_pend_s) begin
        pend_r <= COEF_ZERO;
      end else if (store_pend_s) begin
        pend_r <= cfg.cfg_coef;
      end else begin
        pend_r <= pend_r;
      end
    end
  end

  // Sample-valid delay line matching the NCO latency plus its output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_r <= '0;
    end else if (abort_s || restart_s) begin
      vld_pipe_r <= '0;
    end else begin
      vld_pipe_r <= {vld_pipe_r[NCO_LATENCY-1:0], vld_in_s};
    end
  end

  // FLUSH duration counter, loaded whenever a coefficient change restarts the phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt_r <= FLUSH_ZERO;
    end else if (restart_s) begin
      flush_cnt_r <= FLUSH_LOAD;
    end else if ((state_r == ST_FLUSH) && (flush_cnt_r != FLUSH_ZERO)) begin
      flush_cnt_r <= flush_cnt_r - FLUSH_ONE;
    end else begin
      flush_cnt_r <= flush_cnt_r;
    end
  end

  // One-cycle pulse marking that nco_coef has just changed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_done_r <= 1'b0;
    end else begin
      upd_done_r <= load_cfg_s | load_pend_s;
    end
  end

  assign nco_cntr = cntr_r;
  assign nco_coef = coef_r;
  assign nco_vld  = vld_pipe_r[NCO_LATENCY];
  assign upd_done = upd_done_r;
  assign state    = state_r;

endmodule

// File: tb/tb_jb_nco_ctrl.sv
// Self-checking bench for jb_nco_ctrl: a table of reset/run vectors, directed
// multi-cycle corner sequences, and randomized traffic against a reference model.
module tb_jb_nco_ctrl;
  localparam int CW   = 40;
  localparam int NW   = 39;
  localparam int LAT  = 8;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          sample_en;
  logic [NW-1:0] cnt_max;
  logic [NW-1:0] nco_cntr;
  logic [CW-1:0] nco_coef;
  logic          nco_vld;
  logic          upd_done;
  logic [1:0]    state;

  jb_nco_ctrl_if #(.NCO_COEF_WIDTH(CW)) cfg_if ();

  jb_nco_ctrl #(
    .NCO_COEF_WIDTH (CW),
    .NCO_COUNT_WIDTH(NW),
    .NCO_LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .sample_en(sample_en),
    .cnt_max  (cnt_max),
    .cfg      (cfg_if),
    .nco_cntr (nco_cntr),
    .nco_coef (nco_coef),
    .nco_vld  (nco_vld),
    .upd_done (upd_done),
    .state    (state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode uses the external state numbering, the FLUSH end is
  // an absolute cycle number, and validity is derived from a log of sample
  // issue cycles versus the most recent flush cycle.
  int            cyc;
  int            m_mode;
  logic [NW-1:0] m_cntr;
  logic [CW-1:0] m_coef;
  logic [CW-1:0] m_pend;
  int            m_flush_end;
  int            last_clear;
  bit            m_upd;
  bit            issued [0:MAXC-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_vld(input int n);
    int s;
    s = n - LAT - 1;
    if (s < 0 || s >= MAXC) return 1'b0;
    return issued[s] && (s > last_clear);
  endfunction

  // Advance one clock: check cfg_ready, step the model at the edge, check outputs.
  task automatic tick();
    bit ready_e, hs, wrap, clear, applied;
    #1;
    ready_e = (m_mode == 0) || (m_mode == 1 && enable);
    chk("cfg_ready", 64'(cfg_if.cfg_ready), 64'(ready_e));
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_cntr = '0; m_coef = '0; m_pend = '0; m_upd = 1'b0;
      last_clear = cyc;
    end else begin
      hs = cfg_if.cfg_valid && ready_e;
      wrap = sample_en && (m_cntr == cnt_max);
      m_upd = 1'b0; clear = 1'b0; applied = 1'b0;
      if (sample_en && enable && m_mode != 0 && cyc < MAXC) issued[cyc] = 1'b1;
      if (m_mode == 0) begin
        if (hs) begin m_coef = cfg_if.cfg_coef; m_upd = 1'b1; end
        m_cntr = '0;
        m_mode = enable ? 1 : 0;
      end else if (!enable) begin
        m_mode = 0; m_cntr = '0; m_pend = '0; clear = 1'b1;
      end else if (m_mode == 1 && hs && !cfg_if.cfg_sync) begin
        m_coef = cfg_if.cfg_coef; applied = 1'b1;
      end else if (m_mode == 2 && wrap) begin
        m_coef = m_pend; applied = 1'b1;
      end else begin
        if (sample_en) m_cntr = wrap ? '0 : m_cntr + NW'(1);
        if (m_mode == 1 && hs) begin
          m_pend = cfg_if.cfg_coef; m_mode = 2;
        end else if (m_mode == 3 && cyc >= m_flush_end) begin
          m_mode = 1;
        end
      end
      if (applied) begin
        m_upd = 1'b1; m_cntr = '0; clear = 1'b1; m_mode = 3; m_flush_end = cyc + LAT;
      end
      if (clear) last_clear = cyc;
    end
    cyc++;
    #1;
    chk("state",    64'(state),    64'(m_mode));
    chk("nco_cntr", 64'(nco_cntr), 64'(m_cntr));
    chk("nco_coef", 64'(nco_coef), 64'(m_coef));
    chk("nco_vld",  64'(nco_vld),  64'(exp_vld(cyc)));
    chk("upd_done", 64'(upd_done), 64'(m_upd));
  endtask

  // Tick until the block is in RUN showing the given count, within a cycle budget.
  task automatic wait_run_at(input logic [NW-1:0] c, input string name);
    int k;
    k = 0;
    while (!(state == 2'd1 && nco_cntr == c) && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) begin
      n_vec++; n_err++;
      $display("FAIL %s: timeout waiting for RUN at count %0d", name, c);
    end
  endtask

  typedef struct {
    logic          en;
    logic          se;
    logic          vl;
    logic [CW-1:0] coef;
    logic [1:0]    e_state;
    logic [NW-1:0] e_cntr;
    logic [CW-1:0] e_coef;
    logic          e_vld;
    logic          e_upd;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [63:0] r64;
    int          n_flush, k;
    logic        vld_seen;
    logic [NW-1:0] cnt_seq [0:10];

    reset = 1'b1; enable = 1'b0; sample_en = 1'b0; cnt_max = 39'd4;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_coef = 40'd0; cfg_if.cfg_sync = 1'b0;
    cyc = 0; m_mode = 0; m_cntr = '0; m_coef = '0; m_pend = '0; m_upd = 1'b0;
    m_flush_end = 0; last_clear = 0;

    // Reset values.
    #2;
    chk("rst_state",  64'(state),              64'd0);
    chk("rst_cntr",   64'(nco_cntr),           64'd0);
    chk("rst_coef",   64'(nco_coef),           64'd0);
    chk("rst_vld",    64'(nco_vld),            64'd0);
    chk("rst_upd",    64'(upd_done),           64'd0);
    chk("rst_ready",  64'(cfg_if.cfg_ready),   64'd1);
    tick();
    reset = 1'b0;

    // IDLE handshake, then enable with cnt_max=4 and continuous samples.
    tbl[0] = '{1'b0, 1'b0, 1'b1, 40'h00_1000_0000, 2'd0, 39'd0, 40'h00_1000_0000, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 40'h0,            2'd0, 39'd0, 40'h00_1000_0000, 1'b0, 1'b0};
    cnt_seq[0] = 39'd0; cnt_seq[1] = 39'd1; cnt_seq[2] = 39'd2; cnt_seq[3] = 39'd3;
    cnt_seq[4] = 39'd4; cnt_seq[5] = 39'd0; cnt_seq[6] = 39'd1; cnt_seq[7] = 39'd2;
    cnt_seq[8] = 39'd3; cnt_seq[9] = 39'd4; cnt_seq[10] = 39'd0;
    for (int i = 2; i < 13; i++) begin
      tbl[i] = '{1'b1, 1'b1, 1'b0, 40'h0, 2'd1, cnt_seq[i-2], 40'h00_1000_0000,
                 (i >= 11) ? 1'b1 : 1'b0, 1'b0};
    end
    for (int i = 0; i < 13; i++) begin
      enable = tbl[i].en; sample_en = tbl[i].se;
      cfg_if.cfg_valid = tbl[i].vl; cfg_if.cfg_coef = tbl[i].coef; cfg_if.cfg_sync = 1'b0;
      tick();
      chk("tbl_state", 64'(state),    64'(tbl[i].e_state));
      chk("tbl_cntr",  64'(nco_cntr), 64'(tbl[i].e_cntr));
      chk("tbl_coef",  64'(nco_coef), 64'(tbl[i].e_coef));
      chk("tbl_vld",   64'(nco_vld),  64'(tbl[i].e_vld));
      chk("tbl_upd",   64'(upd_done), 64'(tbl[i].e_upd));
    end
    cfg_if.cfg_valid = 1'b0;

    // Immediate update at count 5 with cnt_max=9.
    cnt_max = 39'd9;
    wait_run_at(39'd5, "imm_wait");
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sync = 1'b0; cfg_if.cfg_coef = 40'h12_3456_789A;
    tick();
    cfg_if.cfg_valid = 1'b0;
    chk("imm_cntr", 64'(nco_cntr), 64'd0);
    chk("imm_coef", 64'(nco_coef), 64'h12_3456_789A);
    n_flush = (state == 2'd3) ? 1 : 0;
    vld_seen = nco_vld;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (state == 2'd3) n_flush++;
      vld_seen = vld_seen | nco_vld;
    end
    chk("imm_flush_len", 64'(n_flush),  64'd8);
    chk("imm_vld_gap",   64'(vld_seen), 64'd0);
    chk("imm_back_run",  64'(state),    64'd1);

    // Wrap-aligned update requested at count 3.
    wait_run_at(39'd3, "sync_wait");
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sync = 1'b1; cfg_if.cfg_coef = 40'hF0_0000_0001;
    tick();
    cfg_if.cfg_valid = 1'b0;
    chk("sync_state",    64'(state),    64'd2);
    chk("sync_coef_old", 64'(nco_coef), 64'h12_3456_789A);
    k = 0;
    do begin tick(); k++; end while (!upd_done && k < 20);
    chk("sync_delay",    64'(k),        64'd6);
    chk("sync_upd_cntr", 64'(nco_cntr), 64'd0);
    chk("sync_coef_new", 64'(nco_coef), 64'hF0_0000_0001);

    // Enable dropped in PEND on the wrap cycle.
    wait_run_at(39'd2, "drop_wait");
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sync = 1'b1; cfg_if.cfg_coef = 40'h00_0000_0055;
    tick();
    cfg_if.cfg_valid = 1'b0;
    k = 0;
    while (nco_cntr != 39'd9 && k < 30) begin tick(); k++; end
    chk("drop_pend", 64'(state), 64'd2);
    enable = 1'b0;
    tick();
    chk("drop_state", 64'(state),    64'd0);
    chk("drop_coef",  64'(nco_coef), 64'hF0_0000_0001);
    chk("drop_upd",   64'(upd_done), 64'd0);
    chk("drop_vld",   64'(nco_vld),  64'd0);
    enable = 1'b1;
    tick();

    // Sync request on the wrap cycle waits a full period.
    wait_run_at(39'd9, "wrapsync_wait");
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_sync = 1'b1; cfg_if.cfg_coef = 40'h00_0000_00AA;
    tick();
    cfg_if.cfg_valid = 1'b0;
    chk("wrapsync_state", 64'(state),    64'd2);
    chk("wrapsync_cntr",  64'(nco_cntr), 64'd0);
    chk("wrapsync_coef",  64'(nco_coef), 64'hF0_0000_0001);
    k = 0;
    do begin tick(); k++; end while (!upd_done && k < 30);
    chk("wrapsync_delay", 64'(k),        64'd10);
    chk("wrapsync_coef2", 64'(nco_coef), 64'h00_0000_00AA);

    // Randomized traffic, including cnt_max=0 and an asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      enable    = ($urandom_range(0, 31) != 0);
      sample_en = ($urandom_range(0, 3) != 0);
      cfg_if.cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_if.cfg_sync  = $urandom_range(0, 1) == 1;
      r64 = {$urandom(), $urandom()};
      cfg_if.cfg_coef = r64[CW-1:0];
      if (n % 200 == 0) begin
        enable  = 1'b0;
        cnt_max = NW'($urandom_range(0, 6));
      end
      if (n == 1500) begin
        reset = 1'b1;
        #2;
        chk("arst_state", 64'(state),            64'd0);
        chk("arst_cntr",  64'(nco_cntr),         64'd0);
        chk("arst_coef",  64'(nco_coef),         64'd0);
        chk("arst_vld",   64'(nco_vld),          64'd0);
        chk("arst_upd",   64'(upd_done),         64'd0);
        chk("arst_ready", 64'(cfg_if.cfg_ready), 64'd1);
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
